// File: rtl/ifu.sv
// ============================================================================
// Module   : ifu
// Purpose  : Instruction fetch unit with single-outstanding bus requests and a
//            2-entry prefetch queue. Define IFU_BYPASS_EN for a 0-cycle
//            bus-to-output path when the queue is empty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] raddr_q, raddr_d;
    logic [31:0] jtgt_q, jtgt_d;
    logic        jpend_q, jpend_d;
    logic        drop_q, drop_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        rptr_q, rptr_d;
    logic [31:0] fa_q [2];
    logic [31:0] fi_q [2];

    logic [31:0] jtarget_w;
    logic        rsp_w;
    logic        bypass_w;
    logic        push_w;
    logic        pop_w;
    logic        wptr_w;
    logic        unused_w;

    assign jtarget_w = {jump_addr_i[31:2], 2'b00};
    assign unused_w  = ^jump_addr_i[1:0];
    assign rsp_w     = (state_q == S_WAIT) && ibus_rvalid_i;
    assign wptr_w    = rptr_q ^ cnt_q[0];

`ifdef IFU_BYPASS_EN
    assign bypass_w = rsp_w && (cnt_q == 2'd0) && !drop_q && !jump_en_i;
`else
    assign bypass_w = 1'b0;
`endif

    assign ibus_req_o   = (state_q == S_REQ);
    assign ibus_addr_o  = pc_q;
    assign inst_valid_o = (cnt_q != 2'd0) || bypass_w;
    assign inst_o       = (cnt_q != 2'd0) ? fi_q[rptr_q] :
                          bypass_w        ? ibus_rdata_i : NOP_INST;
    assign inst_addr_o  = (cnt_q != 2'd0) ? fa_q[rptr_q] :
                          bypass_w        ? raddr_q      : 32'h0;

    // A word handed straight to if_id by the bypass is not queued.
    assign pop_w  = (cnt_q != 2'd0) && inst_ready_i && !jump_en_i;
    assign push_w = rsp_w && !drop_q && !jump_en_i && !(bypass_w && inst_ready_i);

    always_comb begin
        cnt_d  = cnt_q;
        rptr_d = rptr_q;
        if (jump_en_i) begin
            cnt_d = 2'd0;
        end else begin
            cnt_d  = cnt_q + {1'b0, push_w} - {1'b0, pop_w};
            rptr_d = rptr_q ^ pop_w;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        raddr_d = raddr_q;
        jtgt_d  = jtgt_q;
        jpend_d = jpend_q;
        drop_d  = drop_q;
        case (state_q)
            S_IDLE: begin
                if (jump_en_i) begin
                    pc_d    = jtarget_w;
                    state_d = S_REQ;
                end else if (cnt_q != 2'd2) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (ibus_gnt_i) begin
                    raddr_d = pc_q;
                    jpend_d = 1'b0;
                    state_d = S_WAIT;
                    if (jump_en_i) begin
                        pc_d   = jtarget_w;
                        drop_d = 1'b1;
                    end else if (jpend_q) begin
                        pc_d = jtgt_q;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end else if (jump_en_i) begin
                    // Bus address must stay stable until grant, so the
                    // redirect target is parked and applied at grant.
                    jpend_d = 1'b1;
                    jtgt_d  = jtarget_w;
                    drop_d  = 1'b1;
                end
            end
            S_WAIT: begin
                if (ibus_rvalid_i) begin
                    drop_d  = 1'b0;
                    state_d = (cnt_d != 2'd2) ? S_REQ : S_IDLE;
                    if (jump_en_i) begin
                        pc_d = jtarget_w;
                    end
                end else if (jump_en_i) begin
                    pc_d   = jtarget_w;
                    drop_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_ADDR;
            raddr_q <= 32'h0;
            jtgt_q  <= 32'h0;
            jpend_q <= 1'b0;
            drop_q  <= 1'b0;
            cnt_q   <= 2'd0;
            rptr_q  <= 1'b0;
            fa_q[0] <= 32'h0;
            fa_q[1] <= 32'h0;
            fi_q[0] <= 32'h0;
            fi_q[1] <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            raddr_q <= raddr_d;
            jtgt_q  <= jtgt_d;
            jpend_q <= jpend_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
            rptr_q  <= rptr_d;
            if (push_w) begin
                fa_q[wptr_w] <= raddr_q;
                fi_q[wptr_w] <= ibus_rdata_i;
            end
        end
    end

endmodule

`default_nettype wire
